fetch_ctrl: RTL and testbench

//  Sequences instruction fetch: owns the PC register, issues req/ack reads to instruction memory,

---
 rtl/fetch_pkg.sv | 14 +
 rtl/pc_next.sv | 39 +++
 rtl/fetch_ctrl.sv | 145 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
//   fetch_state_t : FSM encoding (request, output-hold, drop-in-flight)
//   PC_STEP       : sequential PC increment in bytes
package fetch_pkg;

  typedef enum logic [1:0] {
    FS_REQ  = 2'd0,
    FS_OUT  = 2'd1,
    FS_DROP = 2'd2
  } fetch_state_t;

  localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/pc_next.sv
// Next-PC selection for fetch_ctrl (purely combinational).
// Priority: flush target > branch target (instr_pc + imm) > sequential step > hold.
// All additions wrap modulo 2^WIDTH.
// Ports:
//   flush      in   redirect to flush_pc
//   branch     in   accepted instruction takes its branch
//   step       in   fetch completed in REQ, advance by PC_STEP
//   pc         in   current PC
//   instr_pc   in   PC of the instruction being accepted
//   imm        in   branch offset
//   flush_pc   in   flush target
//   pc_nxt     out  PC to load on the next clock edge
module pc_next
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             flush,
  input  logic             branch,
  input  logic             step,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] instr_pc,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] flush_pc,
  output logic [WIDTH-1:0] pc_nxt
);

  always_comb begin
    pc_nxt = pc;
    if (flush) begin
      pc_nxt = flush_pc;
    end else if (branch) begin
      pc_nxt = instr_pc + imm;
    end else if (step) begin
      pc_nxt = pc + WIDTH'(PC_STEP);
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, issues req/ack reads to
// instruction memory, presents each fetched word to decode on a valid/ready
// handshake and applies branch and flush redirects.
// Optional build macro: FETCH_CTRL_STATS_EN adds saturating accept/stall counters.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   PCsrc, ImmOp              branch taken / offset for the instruction being accepted
//   flush_i, flush_pc_i       redirect fetch, discard in-flight work
//   mem_req_o, mem_addr_o     memory read request and address
//   mem_ack_i, mem_rdata_i    read completion and data
//   instr_valid_o/ready_i     decode handshake
//   instr_o, instr_pc_o       fetched word and its PC
//   fetch_cnt_o, stall_cnt_o  [FETCH_CTRL_STATS_EN] accepted instrs, valid&&!ready cycles
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               INSTR_W  = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               PCsrc,
  input  logic [WIDTH-1:0]   ImmOp,
  input  logic               flush_i,
  input  logic [WIDTH-1:0]   flush_pc_i,
  output logic               mem_req_o,
  output logic [WIDTH-1:0]   mem_addr_o,
  input  logic               mem_ack_i,
  input  logic [INSTR_W-1:0] mem_rdata_i,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [WIDTH-1:0]   instr_pc_o
`ifdef FETCH_CTRL_STATS_EN
  ,
  output logic [31:0]        fetch_cnt_o,
  output logic [31:0]        stall_cnt_o
`endif
);

  fetch_state_t     state;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_nxt;
  // Address of the request still outstanding while in DROP; pc already holds
  // the redirect target, but the memory must keep seeing the original address.
  logic [WIDTH-1:0] drop_addr;

  logic accept;
  logic req_done;

  assign accept   = (state == FS_OUT) && instr_ready_i;
  assign req_done = (state == FS_REQ) && mem_ack_i;

  assign mem_req_o  = (state != FS_OUT);
  assign mem_addr_o = (state == FS_DROP) ? drop_addr : pc;

  pc_next #(
    .WIDTH (WIDTH)
  ) u_pc_next (
    .flush    (flush_i),
    .branch   (accept && PCsrc),
    .step     (req_done),
    .pc       (pc),
    .instr_pc (instr_pc_o),
    .imm      (ImmOp),
    .flush_pc (flush_pc_i),
    .pc_nxt   (pc_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= FS_REQ;
      pc            <= RESET_PC;
      drop_addr     <= RESET_PC;
      instr_valid_o <= 1'b0;
      instr_o       <= '0;
      instr_pc_o    <= '0;
    end else begin
      pc <= pc_nxt;
      if (flush_i) begin
        instr_valid_o <= 1'b0;
        unique case (state)
          FS_REQ: begin
            // An ack in the same cycle retires the request, nothing left to drop.
            if (mem_ack_i) begin
              state <= FS_REQ;
            end else begin
              state     <= FS_DROP;
              drop_addr <= pc;
            end
          end
          FS_OUT:  state <= FS_REQ;
          FS_DROP: state <= mem_ack_i ? FS_REQ : FS_DROP;
          default: state <= FS_REQ;
        endcase
      end else begin
        unique case (state)
          FS_REQ: begin
            if (mem_ack_i) begin
              instr_o       <= mem_rdata_i;
              instr_pc_o    <= pc;
              instr_valid_o <= 1'b1;
              state         <= FS_OUT;
            end
          end
          FS_OUT: begin
            if (instr_ready_i) begin
              instr_valid_o <= 1'b0;
              state         <= FS_REQ;
            end
          end
          FS_DROP: begin
            if (mem_ack_i) begin
              state <= FS_REQ;
            end
          end
          default: state <= FS_REQ;
        endcase
      end
    end
  end

`ifdef FETCH_CTRL_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_o <= '0;
      stall_cnt_o <= '0;
    end else begin
      // A flush discards the held instruction, so it is not counted as accepted.
      if (accept && !flush_i) begin
        fetch_cnt_o <= sat_inc(fetch_cnt_o);
      end
      if (instr_valid_o && !instr_ready_i) begin
        stall_cnt_o <= sat_inc(stall_cnt_o);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCsrc;
  logic [31:0] ImmOp;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
`ifdef FETCH_CTRL_STATS_EN
  logic [31:0] fetch_cnt_o;
  logic [31:0] stall_cnt_o;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(
    .WIDTH    (32),
    .INSTR_W  (32),
    .RESET_PC (32'h0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .PCsrc         (PCsrc),
    .ImmOp         (ImmOp),
    .flush_i       (flush_i),
    .flush_pc_i    (flush_pc_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_ack_i     (mem_ack_i),
    .mem_rdata_i   (mem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o)
`ifdef FETCH_CTRL_STATS_EN
    ,
    .fetch_cnt_o   (fetch_cnt_o),
    .stall_cnt_o   (stall_cnt_o)
`endif
  );

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        pcsrc;
    logic [31:0] imm;
    logic        flush;
    logic [31:0] fpc;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_ipc;
    logic [31:0] exp_instr;
  } vec_t;

  localparam int NV = 38;
  vec_t vecs[NV];

  function automatic vec_t v(input logic ack, input logic [31:0] rdata, input logic ready,
                             input logic pcsrc, input logic [31:0] imm, input logic flush,
                             input logic [31:0] fpc, input logic exp_req,
                             input logic [31:0] exp_addr, input logic exp_valid,
                             input logic [31:0] exp_ipc, input logic [31:0] exp_instr);
    vec_t r;
    r.ack = ack; r.rdata = rdata; r.ready = ready; r.pcsrc = pcsrc; r.imm = imm;
    r.flush = flush; r.fpc = fpc; r.exp_req = exp_req; r.exp_addr = exp_addr;
    r.exp_valid = exp_valid; r.exp_ipc = exp_ipc; r.exp_instr = exp_instr;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t r);
    mem_ack_i     = r.ack;
    mem_rdata_i   = r.rdata;
    instr_ready_i = r.ready;
    PCsrc         = r.pcsrc;
    ImmOp         = r.imm;
    flush_i       = r.flush;
    flush_pc_i    = r.fpc;
  endtask

  task automatic check_row(input int i, input vec_t r);
    chk($sformatf("row%0d mem_req", i), {31'd0, mem_req_o}, {31'd0, r.exp_req});
    if (r.exp_req) chk($sformatf("row%0d mem_addr", i), mem_addr_o, r.exp_addr);
    chk($sformatf("row%0d valid", i), {31'd0, instr_valid_o}, {31'd0, r.exp_valid});
    if (r.exp_valid) begin
      chk($sformatf("row%0d instr_pc", i), instr_pc_o, r.exp_ipc);
      chk($sformatf("row%0d instr", i), instr_o, r.exp_instr);
    end
  endtask

  initial begin
    // Columns: ack rdata ready pcsrc imm flush fpc | req addr valid ipc instr
    // Sequential fetch 0,4,8,C with ready=1
    vecs[0]  = v(1, 32'hA0, 0, 0, 0, 0, 0,  1, 32'h0, 0, 0, 0);
    vecs[1]  = v(0, 0, 1, 0, 0, 0, 0,       0, 0, 1, 32'h0, 32'hA0);
    vecs[2]  = v(1, 32'hA4, 0, 0, 0, 0, 0,  1, 32'h4, 0, 0, 0);
    vecs[3]  = v(0, 0, 1, 0, 0, 0, 0,       0, 0, 1, 32'h4, 32'hA4);
    vecs[4]  = v(1, 32'hA8, 0, 0, 0, 0, 0,  1, 32'h8, 0, 0, 0);
    vecs[5]  = v(0, 0, 1, 0, 0, 0, 0,       0, 0, 1, 32'h8, 32'hA8);
    vecs[6]  = v(1, 32'hAC, 0, 0, 0, 0, 0,  1, 32'hC, 0, 0, 0);
    // Branch from C by -4 back to 8, then from 8 by -8 to 0
    vecs[7]  = v(0, 0, 1, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 1, 32'hC, 32'hAC);
    vecs[8]  = v(1, 32'hB8, 0, 0, 0, 0, 0,  1, 32'h8, 0, 0, 0);
    vecs[9]  = v(0, 0, 1, 1, 32'hFFFF_FFF8, 0, 0, 0, 0, 1, 32'h8, 32'hB8);
    vecs[10] = v(1, 32'hC0, 0, 0, 0, 0, 0,  1, 32'h0, 0, 0, 0);
    // Five stall cycles; PCsrc during a stall must not redirect
    vecs[11] = v(0, 0, 0, 0, 0, 0, 0,       0, 0, 1, 32'h0, 32'hC0);
    vecs[12] = v(0, 0, 0, 0, 0, 0, 0,       0, 0, 1, 32'h0, 32'hC0);
    vecs[13] = v(0, 0, 0, 1, 32'h40, 0, 0,  0, 0, 1, 32'h0, 32'hC0);
    vecs[14] = v(0, 0, 0, 0, 0, 0, 0,       0, 0, 1, 32'h0, 32'hC0);
    vecs[15] = v(0, 0, 0, 0, 0, 0, 0,       0, 0, 1, 32'h0, 32'hC0);
    vecs[16] = v(0, 0, 1, 0, 0, 0, 0,       0, 0, 1, 32'h0, 32'hC0);
    // Memory wait state before ack
    vecs[17] = v(0, 0, 0, 0, 0, 0, 0,       1, 32'h4, 0, 0, 0);
    vecs[18] = v(1, 32'hD4, 0, 0, 0, 0, 0,  1, 32'h4, 0, 0, 0);
    vecs[19] = v(0, 0, 1, 0, 0, 0, 0,       0, 0, 1, 32'h4, 32'hD4);
    // Flush in REQ, ack delayed three cycles: DROP keeps the old address
    vecs[20] = v(0, 0, 0, 0, 0, 1, 32'h100, 1, 32'h8, 0, 0, 0);
    vecs[21] = v(0, 0, 0, 0, 0, 0, 0,       1, 32'h8, 0, 0, 0);
    vecs[22] = v(0, 0, 0, 0, 0, 0, 0,       1, 32'h8, 0, 0, 0);
    vecs[23] = v(1, 32'hEE, 0, 0, 0, 0, 0,  1, 32'h8, 0, 0, 0);
    vecs[24] = v(1, 32'h11, 0, 0, 0, 0, 0,  1, 32'h100, 0, 0, 0);
    vecs[25] = v(0, 0, 1, 0, 0, 0, 0,       0, 0, 1, 32'h100, 32'h11);
    // Flush together with branch on accept: flush wins
    vecs[26] = v(1, 32'h22, 0, 0, 0, 0, 0,  1, 32'h104, 0, 0, 0);
    vecs[27] = v(0, 0, 1, 1, 32'h40, 1, 32'h200, 0, 0, 1, 32'h104, 32'h22);
    // Flush in REQ with ack in the same cycle: data discarded, stay in REQ
    vecs[28] = v(1, 32'h33, 0, 0, 0, 1, 32'h300, 1, 32'h200, 0, 0, 0);
    vecs[29] = v(1, 32'h44, 0, 0, 0, 0, 0,  1, 32'h300, 0, 0, 0);
    vecs[30] = v(0, 0, 1, 0, 0, 0, 0,       0, 0, 1, 32'h300, 32'h44);
    // PC wrap at the top of the address space
    vecs[31] = v(1, 32'h55, 0, 0, 0, 1, 32'hFFFF_FFFC, 1, 32'h304, 0, 0, 0);
    vecs[32] = v(1, 32'h66, 0, 0, 0, 0, 0,  1, 32'hFFFF_FFFC, 0, 0, 0);
    vecs[33] = v(0, 0, 1, 0, 0, 0, 0,       0, 0, 1, 32'hFFFF_FFFC, 32'h66);
    vecs[34] = v(1, 32'h77, 0, 0, 0, 0, 0,  1, 32'h0, 0, 0, 0);
    vecs[35] = v(0, 0, 1, 0, 0, 0, 0,       0, 0, 1, 32'h0, 32'h77);
    // Enter DROP, then reset arrives mid-DROP below
    vecs[36] = v(0, 0, 0, 0, 0, 1, 32'h400, 1, 32'h4, 0, 0, 0);
    vecs[37] = v(0, 0, 0, 0, 0, 0, 0,       1, 32'h4, 0, 0, 0);

    // Reset with ack asserted: must not be honoured while rst=1
    rst = 1'b1;
    drive(v(1, 32'hDEAD, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (3) @(posedge clk);
    #1;
    chk("reset mem_req", {31'd0, mem_req_o}, 32'd1);
    chk("reset mem_addr", mem_addr_o, 32'h0);
    chk("reset valid", {31'd0, instr_valid_o}, 32'd0);
    chk("reset instr", instr_o, 32'h0);
    chk("reset instr_pc", instr_pc_o, 32'h0);
`ifdef FETCH_CTRL_STATS_EN
    chk("reset fetch_cnt", fetch_cnt_o, 32'd0);
    chk("reset stall_cnt", stall_cnt_o, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      if (i != 0) @(negedge clk);
      drive(vecs[i]);
      #1;
      check_row(i, vecs[i]);
      @(posedge clk);
    end

`ifdef FETCH_CTRL_STATS_EN
    #1;
    chk("fetch_cnt", fetch_cnt_o, 32'd11);
    chk("stall_cnt", stall_cnt_o, 32'd5);
`endif

    // Asynchronous reset in the middle of a DROP cycle
    drive(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #3;
    chk("pre-rst mem_addr drop", mem_addr_o, 32'h4);
    rst = 1'b1;
    #1;
    chk("mid-drop rst mem_req", {31'd0, mem_req_o}, 32'd1);
    chk("mid-drop rst mem_addr", mem_addr_o, 32'h0);
    chk("mid-drop rst valid", {31'd0, instr_valid_o}, 32'd0);
    chk("mid-drop rst instr", instr_o, 32'h0);
    chk("mid-drop rst instr_pc", instr_pc_o, 32'h0);
`ifdef FETCH_CTRL_STATS_EN
    chk("mid-drop rst fetch_cnt", fetch_cnt_o, 32'd0);
    chk("mid-drop rst stall_cnt", stall_cnt_o, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Fetch resumes from RESET_PC
    drive(v(1, 32'h88, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    check_row(100, v(0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0, 0));
    @(negedge clk);
    drive(v(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    check_row(101, v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h88));
    @(negedge clk);
    #1;
    check_row(102, v(0, 0, 0, 0, 0, 0, 0, 1, 32'h4, 0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
